// File: rtl/mul_seq_ctrl.sv
// Sequential radix-2 shift-add multiplier for RV64 MUL/MULH/MULHSU/MULHU/MULW.
// One operand bit per cycle; results are written in FIX and held until the next completion.
module mul_seq_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      MULControl,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [2:0] OP_MUL    = 3'b100;
    localparam logic [2:0] OP_MULH   = 3'b101;
    localparam logic [2:0] OP_MULHSU = 3'b110;
    localparam logic [2:0] OP_MULHU  = 3'b111;
    localparam logic [2:0] OP_MULW   = 3'b011;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              ready_q, busy_q, done_q;

    logic              accept;
    logic              a_sgn, b_sgn;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              op_legal_q;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] prod;

    assign accept = start && ready_q && !flush;

    // Operand magnitudes and result sign derived from the live inputs at accept time.
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        a_mag = rs1;
        b_mag = rs2;
        case (MULControl)
            OP_MUL, OP_MULH: begin
                a_sgn = rs1[XLEN-1];
                b_sgn = rs2[XLEN-1];
            end
            OP_MULHSU: a_sgn = rs1[XLEN-1];
            OP_MULW: begin
                a_mag = {{(XLEN-32){1'b0}}, rs1[31:0]};
                b_mag = {{(XLEN-32){1'b0}}, rs2[31:0]};
            end
            default: ;
        endcase
        if (a_sgn) a_mag = -rs1;
        if (b_sgn) b_mag = -rs2;
    end

    always_comb begin
        op_legal_q = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                     (op_q == OP_MULHU) || (op_q == OP_MULW);
        sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (mplier_q[0] ? mcand_q : {XLEN{1'b0}})};
        prod = neg_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d     = MULControl;
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = a_sgn ^ b_sgn;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                // Zero/illegal bypass is decided on the captured operands in the first CALC cycle.
                if (cnt_q == 6'd0 && (mcand_q == '0 || mplier_q == '0 || !op_legal_q)) begin
                    acc_d   = '0;
                    state_d = FIX;
                end else begin
                    acc_d    = {sum, acc_q[XLEN-1:1]};
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == 6'd63) state_d = FIX;
                end
            end
            FIX: begin
                case (op_q)
                    OP_MUL:                       result_d = prod[XLEN-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod[2*XLEN-1:XLEN];
                    OP_MULW:                      result_d = {{(XLEN-32){prod[31]}}, prod[31:0]};
                    default:                      result_d = '0;
                endcase
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= (state_d == IDLE);
            busy_q   <= (state_d == CALC) || (state_d == FIX);
            done_q   <= (state_d == DONE);
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: arithmetic vectors, latency, zero path, flush and reset.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [2:0]  MULControl;
    logic        ready;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        string       name;
    } vec_t;

    mul_seq_ctrl #(.XLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rs1        (rs1),
        .rs2        (rs2),
        .MULControl (MULControl),
        .flush      (flush),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        start = 1'b1;
        MULControl = op;
        rs1 = a;
        rs2 = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // lat = number of edges after the accept edge until done is seen (-1 on timeout).
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        rs1 = '0; rs2 = '0; MULControl = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== 64'h0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b expected 1", ready); end
    endtask

    task automatic test_mul_latency();
        int lat, bc;
        issue(3'b100, 64'd3, 64'd5);
        wait_done(lat, bc);
        checks++; if (lat !== 65) begin failures++; $display("FAIL mul_latency: got %0d expected 65", lat); end
        checks++; if (bc !== 65) begin failures++; $display("FAIL mul_busy_cycles: got %0d expected 65", bc); end
        checks++; if (result !== 64'd15) begin failures++; $display("FAIL mul_3x5: got %h expected %h", result, 64'd15); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle: got %b expected 0", done); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL ready_after_done: got %b expected 1", ready); end
        checks++; if (result !== 64'd15) begin failures++; $display("FAIL result_held: got %h expected %h", result, 64'd15); end
    endtask

    task automatic test_arith();
        vec_t v[$];
        int lat, bc;
        v.push_back('{3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, "mulh_m1_m1"});
        v.push_back('{3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, "mul_m1_m1"});
        v.push_back('{3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h1, "mulhu_max_2"});
        v.push_back('{3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, "mulhsu_m1_2"});
        v.push_back('{3'b011, 64'h7FFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFE, "mulw_ovf"});
        v.push_back('{3'b011, 64'hDEAD_0000_0000_0002, 64'h1234_0000_0000_0003, 64'h6, "mulw_upper_ignored"});
        v.push_back('{3'b011, 64'hFFFF_FFFF, 64'h3, 64'hFFFF_FFFF_FFFF_FFFD, "mulw_neg"});
        v.push_back('{3'b100, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, "mul_m3_5"});
        v.push_back('{3'b101, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, "mulh_m3_5"});
        v.push_back('{3'b101, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, "mulh_min_min"});
        v.push_back('{3'b111, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1, "mulhu_2p32_sq"});
        foreach (v[i]) begin
            issue(v[i].op, v[i].a, v[i].b);
            wait_done(lat, bc);
            checks++; if (lat !== 65) begin failures++; $display("FAIL %s_latency: got %0d expected 65", v[i].name, lat); end
            checks++; if (result !== v[i].exp) begin failures++; $display("FAIL %s: got %h expected %h", v[i].name, result, v[i].exp); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_zero_path();
        vec_t v[$];
        int lat, bc;
        v.push_back('{3'b100, 64'd3, 64'd0, 64'h0, "zero_rs2"});
        v.push_back('{3'b101, 64'd0, 64'd5, 64'h0, "zero_rs1"});
        v.push_back('{3'b001, 64'd3, 64'd5, 64'h0, "illegal_001"});
        v.push_back('{3'b000, 64'd3, 64'd5, 64'h0, "illegal_000"});
        v.push_back('{3'b011, 64'hFFFF_FFFF_0000_0000, 64'd5, 64'h0, "mulw_low_zero"});
        foreach (v[i]) begin
            issue(3'b100, 64'd3, 64'd5);
            wait_done(lat, bc);
            @(posedge clk);
            #1;
            issue(v[i].op, v[i].a, v[i].b);
            wait_done(lat, bc);
            checks++; if (lat !== 2) begin failures++; $display("FAIL %s_latency: got %0d expected 2", v[i].name, lat); end
            checks++; if (bc !== 2) begin failures++; $display("FAIL %s_busy_cycles: got %0d expected 2", v[i].name, bc); end
            checks++; if (result !== v[i].exp) begin failures++; $display("FAIL %s: got %h expected %h", v[i].name, result, v[i].exp); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_flush_priority();
        int dcnt = 0;
        @(negedge clk);
        start = 1'b1; flush = 1'b1; MULControl = 3'b100; rs1 = 64'd4; rs2 = 64'd4;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL flush_prio_ready: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_prio_busy: got %b expected 0", busy); end
        for (int n = 0; n < 70; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcnt++;
        end
        checks++; if (dcnt !== 0) begin failures++; $display("FAIL flush_prio_no_done: got %0d expected 0", dcnt); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        issue(3'b100, 64'd7, 64'd6);
        wait_done(lat, bc);
        checks++; if (result !== 64'd42) begin failures++; $display("FAIL b2b_first: got %h expected %h", result, 64'd42); end
        // start while in DONE (ready=0) must be dropped
        start = 1'b1; MULControl = 3'b100; rs1 = 64'd100; rs2 = 64'd100;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_done_start_ready: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_done_start_busy: got %b expected 0", busy); end
        issue(3'b100, 64'd9, 64'd9);
        wait_done(lat, bc);
        checks++; if (lat !== 65) begin failures++; $display("FAIL b2b_second_latency: got %0d expected 65", lat); end
        checks++; if (result !== 64'd81) begin failures++; $display("FAIL b2b_second: got %h expected %h", result, 64'd81); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_flush();
        int dcnt = 0;
        issue(3'b100, 64'd3, 64'd5);
        @(posedge clk);
        #1;
        start = 1'b1; MULControl = 3'b100; rs1 = 64'd7; rs2 = 64'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy_in_calc: got %b expected 1", busy); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL flush_ready_in_calc: got %b expected 0", ready); end
        repeat (7) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL flush_ready: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL flush_done: got %b expected 0", done); end
        checks++; if (result !== 64'd81) begin failures++; $display("FAIL flush_result: got %h expected %h", result, 64'd81); end
        for (int n = 0; n < 80; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcnt++;
        end
        checks++; if (dcnt !== 0) begin failures++; $display("FAIL flush_no_done: got %0d expected 0", dcnt); end
        checks++; if (result !== 64'd81) begin failures++; $display("FAIL flush_result_later: got %h expected %h", result, 64'd81); end
    endtask

    task automatic test_rst_mid_calc();
        int dcnt = 0;
        int lat, bc;
        issue(3'b100, 64'd3, 64'd5);
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (result !== 64'h0) begin failures++; $display("FAIL rst_async_result: got %h expected 0", result); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready: got %b expected 1", ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b expected 1", ready); end
        for (int n = 0; n < 80; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcnt++;
        end
        checks++; if (dcnt !== 0) begin failures++; $display("FAIL rst_no_done: got %0d expected 0", dcnt); end
        issue(3'b100, 64'd12, 64'd11);
        wait_done(lat, bc);
        checks++; if (result !== 64'd132) begin failures++; $display("FAIL rst_recover: got %h expected %h", result, 64'd132); end
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_arith();
        test_zero_path();
        test_flush_priority();
        test_back_to_back();
        test_flush();
        test_rst_mid_calc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
